data_mem_hs: RTL
================

// Module: data_mem_hs
// PURPOSE
//   Byte-addressable, parametrised data memory with valid/ready request and response handshake.
//   Supports byte/half/word(/dword) loads and stores, sign or zero extension, and misalignment errors.
//   Replaces the single-cycle word memory for the multicycle/pipelined MIPS datapath (LSU <-> DMEM).
//   The programmable LATENCY models slow memory.
// PARAMETERS
//   DATA      32   data width; legal values 32 or 64; lanes NB = DATA/8
//   ADDR      32   byte-address width
//   MEM_DEPTH 256  number of DATA-wide words
//   LATENCY   2    cycles from request accept to response; >= 1
// PORTS
//   clk          in   1     clock, rising edge
//   rstn         in   1     asynchronous active-low reset
//   req_valid    in   1     request present
//   req_ready    out  1     block can accept request
//   req_we       in   1     1 = store, 0 = load
//   req_size     in   2     00 byte, 01 half, 10 word(32b), 11 dword (DATA=64 only)
//   req_unsigned in   1     load zero-extends when 1, sign-extends when 0
//   req_addr     in   ADDR  byte address
//   req_wdata    in   DATA  store data, right-justified
//   resp_valid   out  1     one-cycle response pulse
//   resp_rdata   out  DATA  load result, extended to DATA; 0 for stores and errors
//   resp_err     out  1     request rejected (misaligned or illegal size), valid with resp_valid
//   test_value   out  DATA  combinational copy of word 0 (bench observation)
// BEHAVIOUR
//   - Address decode:
//       lane  = req_addr[log2(NB)-1:0]
//       index = req_addr[ADDR-1:log2(NB)] mod MEM_DEPTH (upper bits wrap silently, no error)
//   - Error cases:
//       half with addr[0]!=0; word with addr[1:0]!=0; dword with addr[2:0]!=0;
//       size 11 when DATA=32.
//       Errored requests never write memory; they respond with err=1, rdata=0, same latency.
//   - FSM:
//       IDLE (req_ready=1) -> on req_valid&req_ready: capture request, cnt<=LATENCY-1,
//         go WAIT, or go RESP if LATENCY=1.
//       WAIT (req_ready=0) -> cnt decrements each cycle; at cnt==1 go RESP.
//       RESP -> resp_valid=1 for exactly one cycle, then IDLE.
//       req_valid is ignored while req_ready=0; there is no queueing.
//   - Timing:
//       Accept at edge T -> resp_valid high on the cycle after edge T+LATENCY.
//       Throughput is one request per LATENCY+1 cycles.
//   - Commit: the store write and the load read both occur at the edge entering RESP.
//     A load issued after a store therefore returns the stored data.
//   - Stores: only the addressed lanes are written; the other lanes keep their value. Lane order is little-endian.
//   - Loads: extract the addressed lanes, then sign- or zero-extend to DATA. Full-width loads ignore req_unsigned.
//   - test_value always reflects mem[0], including a store committed in the same cycle (after the edge).
//   - Reset (async): all memory words 0, FSM IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
//     Reset mid-request aborts it: no write, no response.
// CONFIGURATION
//   DMEM_PARITY_EN defined:
//     - One parity bit per byte lane is stored alongside the memory.
//     - Adds port parity_inject (in, 1): when high at accept, the parity of a store is written inverted.
//     - Loads recompute parity over the addressed lanes; any mismatch sets resp_err=1 and returns the data anyway.
//     - Reset clears all parity bits to 0 (consistent with zero data).
//   DMEM_PARITY_EN undefined: no parity storage and no parity_inject port; resp_err is alignment/size only.
// TESTING (DATA=32, LATENCY=2 unless noted)
//   - Reset, then word load at 0x0 -> resp_valid 3 cycles after accept, rdata=0, err=0; test_value=0.
//   - Store word 0x8000_00F0 at 0x4; load byte 0x4 signed -> 0xFFFF_FFF0; load byte 0x4 unsigned -> 0x0000_00F0;
//     load half 0x6 signed -> 0xFFFF_8000.
//   - Store byte 0xAB at 0x1 over word 0 = 0x1122_3344 -> test_value=0x1122_AB44.
//   - Half store at 0x3 -> err=1, memory unchanged; size 11 on DATA=32 -> err=1.
//   - Address 0x400 with MEM_DEPTH=256 wraps to word 0.
//   - Assert rstn low while in WAIT -> no write, no resp_valid, req_ready=1 after release.
//   - Parity (with DMEM_PARITY_EN): store with parity_inject=1, then load -> err=1 and data returned.

Source files
------------

// File: rtl/data_mem_hs.sv
// Byte-addressable data memory with valid/ready request and response handshake.
// Loads/stores of byte/half/word(/dword), sign or zero extension, misalignment errors.
// Ports: clk, rstn (async active-low); req_valid_i/req_ready_o, req_we_i, req_size_i,
//   req_unsigned_i, req_addr_i, req_wdata_i; resp_valid_o, resp_rdata_o, resp_err_o;
//   test_value_o (word 0). Macro DMEM_PARITY_EN adds per-lane parity and parity_inject_i.
module data_mem_hs #(
  parameter int DATA      = 32,
  parameter int ADDR      = 32,
  parameter int MEM_DEPTH = 256,
  parameter int LATENCY   = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic            req_we_i,
  input  logic [1:0]      req_size_i,
  input  logic            req_unsigned_i,
  input  logic [ADDR-1:0] req_addr_i,
  input  logic [DATA-1:0] req_wdata_i,
`ifdef DMEM_PARITY_EN
  input  logic            parity_inject_i,
`endif
  output logic            resp_valid_o,
  output logic [DATA-1:0] resp_rdata_o,
  output logic            resp_err_o,
  output logic [DATA-1:0] test_value_o
);

  localparam int NB = DATA / 8;
  localparam int LW = $clog2(NB);
  localparam int IW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic              ready_q;
  logic              rvalid_q;
  logic              rerr_q;
  logic [DATA-1:0]   rdata_q;
  logic              we_q;
  logic              uns_q;
  logic [1:0]        size_q;
  logic [ADDR-1:0]   addr_q;
  logic [DATA-1:0]   wdata_q;
  logic [DATA-1:0]   mem_q [MEM_DEPTH];

  logic              idle;
  logic              accept;
  logic              commit;
  logic              c_we;
  logic              c_uns;
  logic [1:0]        c_size;
  logic [ADDR-1:0]   c_addr;
  logic [DATA-1:0]   c_wdata;

  logic [LW-1:0]     lane;
  logic [IW-1:0]     idx;
  int                nb;
  int                sb;
  logic [DATA-1:0]   old_w;
  logic [DATA-1:0]   sh_w;
  logic [DATA-1:0]   sh_r;
  logic [DATA-1:0]   new_w;
  logic [DATA-1:0]   ld;
  logic [NB-1:0]     bm;
  logic              misal;
  logic              perr;

  assign idle   = (state_q == IDLE);
  assign accept = req_valid_i & ready_q;
  // With LATENCY=1 the commit edge is the accept edge, so use live inputs.
  assign commit = (idle & accept & (LATENCY == 1))
                | ((state_q == WAIT) & (cnt_q == CW'(1)));

  assign c_we    = idle ? req_we_i       : we_q;
  assign c_uns   = idle ? req_unsigned_i : uns_q;
  assign c_size  = idle ? req_size_i     : size_q;
  assign c_addr  = idle ? req_addr_i     : addr_q;
  assign c_wdata = idle ? req_wdata_i    : wdata_q;

  always_comb begin
    lane  = c_addr[LW-1:0];
    idx   = IW'((c_addr >> LW) % MEM_DEPTH);
    nb    = 1 << c_size;
    sb    = ((nb * 8 > DATA) ? DATA : nb * 8) - 1;
    old_w = mem_q[idx];
    sh_w  = c_wdata << {lane, 3'b000};
    sh_r  = old_w >> {lane, 3'b000};
    new_w = old_w;
    bm    = '0;
    ld    = '0;
    for (int b = 0; b < NB; b++) begin
      bm[b] = (b >= int'(lane)) && (b < int'(lane) + nb);
      if (bm[b]) new_w[b*8 +: 8] = sh_w[b*8 +: 8];
    end
    for (int i = 0; i < DATA; i++) begin
      ld[i] = (i < nb * 8) ? sh_r[i] : (~c_uns & sh_r[sb]);
    end
    unique case (c_size)
      2'd0:    misal = 1'b0;
      2'd1:    misal = c_addr[0];
      2'd2:    misal = |c_addr[1:0];
      default: misal = (DATA == 32) | (|c_addr[2:0]);
    endcase
  end

`ifdef DMEM_PARITY_EN
  logic [NB-1:0] par_q [MEM_DEPTH];
  logic [NB-1:0] new_p;
  logic [NB-1:0] calc_p;
  logic          inj_q;
  logic          c_inj;

  assign c_inj = idle ? parity_inject_i : inj_q;

  always_comb begin
    new_p  = par_q[idx];
    calc_p = '0;
    for (int b = 0; b < NB; b++) begin
      calc_p[b] = ^old_w[b*8 +: 8];
      if (bm[b]) new_p[b] = (^sh_w[b*8 +: 8]) ^ c_inj;
    end
    perr = |(bm & (calc_p ^ par_q[idx]));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      inj_q <= 1'b0;
      for (int i = 0; i < MEM_DEPTH; i++) par_q[i] <= '0;
    end else begin
      if (idle && accept) inj_q <= parity_inject_i;
      if (commit && c_we && !misal) par_q[idx] <= new_p;
    end
  end
`else
  always_comb perr = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MEM_DEPTH; i++) mem_q[i] <= '0;
    end else if (commit && c_we && !misal) begin
      mem_q[idx] <= new_w;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      rvalid_q <= 1'b0;
      if (commit) begin
        rdata_q <= (c_we | misal) ? '0 : ld;
        rerr_q  <= misal | (~c_we & perr);
      end
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            we_q    <= req_we_i;
            uns_q   <= req_unsigned_i;
            size_q  <= req_size_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
            cnt_q   <= CW'(LATENCY - 1);
            ready_q <= 1'b0;
            state_q <= (LATENCY == 1) ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_q <= RESP;
        end
        RESP: begin
          rvalid_q <= 1'b1;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o  = ready_q;
  assign resp_valid_o = rvalid_q;
  assign resp_rdata_o = rdata_q;
  assign resp_err_o   = rerr_q;
  assign test_value_o = mem_q[0];

endmodule
